// File: rtl/sync_fifo_ctrl_16x8.sv
// FIFO controller mastering an external 16x8 synchronous dual-port RAM.
// Tracks occupancy and pointers, issues RAM read/write strobes and flags misuse.
module sync_fifo_ctrl_16x8 #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_wr_enb,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_enb,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_pop_vld_p1;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push_acc;
  logic w_pop_acc;
  logic w_push_drop;
  logic w_pop_drop;

  function automatic logic [ADDR_WIDTH:0] next_count(
    input logic [ADDR_WIDTH:0] c,
    input logic                inc,
    input logic                dec
  );
    logic [ADDR_WIDTH:0] n;
    n = c;
    case ({inc, dec})
      2'b10:   n = c + 1'b1;
      2'b01:   n = c - 1'b1;
      default: n = c;
    endcase
    return n;
  endfunction

  // Stage p0: flag decode and request acceptance, all combinational
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // A push into a full FIFO is legal when a pop frees a slot in the same cycle;
  // the RAM's read-before-write behaviour returns the old word to the reader.
  assign w_push_acc  = push & (~w_full | pop) & ~rst;
  assign w_pop_acc   = pop & ~w_empty & ~rst;
  assign w_push_drop = push & w_full & ~pop;
  assign w_pop_drop  = pop & w_empty;

  assign ram_wr_enb  = w_push_acc;
  assign ram_wr_addr = r_wr_ptr;
  assign ram_wr_data = push_data;
  assign ram_rd_enb  = w_pop_acc;
  assign ram_rd_addr = r_rd_ptr;

  // Stage p0 -> p1: pointer, occupancy and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_pop_vld_p1 <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count      <= next_count(r_count, w_push_acc, w_pop_acc);
      r_pop_vld_p1 <= w_pop_acc;
      if (w_push_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_pop_drop) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Stage p1: RAM read data arrives one cycle after the accepted pop
  assign pop_data  = ram_rd_data;
  assign pop_valid = r_pop_vld_p1;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: doc/sync_fifo_ctrl_16x8.md
SYNC_FIFO_CTRL_16X8 -- requirements
Module: sync_fifo_ctrl_16x8

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_WIDTH, 4, RAM address width.
  DEPTH, 16, number of entries; equals 2**ADDR_WIDTH.
  DATA_WIDTH, 8, data word width.
REQ-002 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst. All state SHALL update on posedge clk.
REQ-003 Ports SHALL be, one per line:
  clk  input  1  clock
  rst  input  1  synchronous active-high reset
  push  input  1  write request
  push_data  input  DATA_WIDTH  write word
  pop  input  1  read request
  pop_data  output  DATA_WIDTH  read word; valid when pop_valid=1
  pop_valid  output  1  pop_data qualifier, registered
  full  output  1  count==DEPTH
  empty  output  1  count==0
  count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
  overflow  output  1  sticky: push rejected
  underflow  output  1  sticky: pop rejected
  ram_wr_enb  output  1  to RAM write enable
  ram_wr_addr  output  ADDR_WIDTH  to RAM write address
  ram_wr_data  output  DATA_WIDTH  to RAM write data
  ram_rd_enb  output  1  to RAM read enable
  ram_rd_addr  output  ADDR_WIDTH  to RAM read address
  ram_rd_data  input  DATA_WIDTH  from RAM read data; 1-cycle latency

Function
REQ-004 The block SHALL master the write and read ports of the team's 16x8 synchronous dual-port RAM, where a read returns data on the cycle after rd_enb, and a same-address same-cycle read returns the old contents.
REQ-005 Internal state SHALL be: wr_ptr and rd_ptr (ADDR_WIDTH bits each), count, pop_valid, overflow and underflow.
REQ-006 push_acc SHALL equal push & (~full | pop); pop_acc SHALL equal pop & ~empty. Both are combinational.
REQ-007 ram_wr_enb SHALL equal push_acc, ram_wr_addr SHALL equal wr_ptr, and ram_wr_data SHALL equal push_data.
REQ-008 ram_rd_enb SHALL equal pop_acc, and ram_rd_addr SHALL equal rd_ptr.
REQ-009 On push_acc, wr_ptr SHALL increment by 1 modulo DEPTH (15 wraps to 0). On pop_acc, rd_ptr SHALL increment the same way.
REQ-010 count SHALL change as follows: +1 on push_acc only; -1 on pop_acc only; unchanged when both or neither occur.
REQ-011 full and empty SHALL be decoded combinationally from the registered count.
REQ-012 Push when full, with pop active, SHALL be accepted. Count stays DEPTH, and the popped word is the old entry (RAM read-before-write).
REQ-013 Push when full, without pop, SHALL be dropped: no RAM write, no pointer change. overflow SHALL be set on the next edge.
REQ-014 Pop when empty SHALL be rejected even if push is active. underflow SHALL be set on the next edge. A simultaneous push SHALL still be accepted.
REQ-015 pop_valid SHALL be registered pop_acc, asserting exactly 1 cycle after an accepted pop. pop_data SHALL equal ram_rd_data directly.
REQ-016 Read latency SHALL be 1 cycle: pop accepted at edge N gives pop_valid=1 and pop_data valid during the cycle after edge N.
REQ-017 Data SHALL emerge in push order, with no loss or duplication over wrap-around.
REQ-018 overflow and underflow SHALL remain set until rst.

Reset
REQ-019 While rst=1 at posedge clk, the following SHALL be cleared: wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, overflow=0, underflow=0.
REQ-020 During rst, push_acc and pop_acc SHALL be forced to 0, so ram_wr_enb=0 and ram_rd_enb=0.
REQ-021 Reset after reset: empty=1, full=0.
REQ-022 Reset mid-operation SHALL discard all contents, and any pop_valid due on the following cycle SHALL be suppressed.
REQ-023 rst SHALL be shared with the RAM rst.

Verification
REQ-024 The bench SHALL cover these scenarios:
  - Reset, then idle: count=0, empty=1, full=0, pop_valid=0, overflow=0, underflow=0.
  - Push 0xA1, 0xB2, 0xC3, then pop 3 times back-to-back: pop_valid high for 3 cycles, each 1 cycle after its pop; data 0xA1, 0xB2, 0xC3; empty=1 afterwards.
  - Push 16 words 0x00..0x0F: full=1, count=16. A 17th push with no pop: no RAM write, overflow=1, count=16.
  - When full: push 0x55 with pop in the same cycle: pop returns 0x00, count stays 16. Then drain 16: data 0x01..0x0F followed by 0x55.
  - When empty: push 0x77 with pop in the same cycle: pop rejected, underflow=1, count=1. The next pop returns 0x77.
  - Pointer wrap: 40 interleaved push/pop operations with random data match a reference queue. Assert rst mid-stream: count=0 on the next cycle, no pop_valid.
